// File: rtl/strength_pkg.sv
// Shared types and helpers for the wired-net strength resolver.
// Strength codes follow Verilog ordering, highz (0) through supply (7).
package strength_pkg;

  typedef enum logic [2:0] {
    HIGHZ  = 3'd0,
    SMALL  = 3'd1,
    MEDIUM = 3'd2,
    WEAK   = 3'd3,
    LARGE  = 3'd4,
    PULL   = 3'd5,
    STRONG = 3'd6,
    SUPPLY = 3'd7
  } strength_t;

  // 4-state encoding as {xz, val}
  localparam logic [1:0] FS_ZERO = 2'b00;
  localparam logic [1:0] FS_ONE  = 2'b01;
  localparam logic [1:0] FS_Z    = 2'b10;
  localparam logic [1:0] FS_X    = 2'b11;

  function automatic logic [2:0] max_strength(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/strength_bit_reduce.sv
// Combinational reduction of all drivers of one net bit to the strongest 0 and 1 drive.
// With STRENGTH_RESOLVER_WINNER_EN it also reports the lowest-index driver holding each maximum.
module strength_bit_reduce
  import strength_pkg::*;
#(
  parameter int NUM_DRV = 3
`ifdef STRENGTH_RESOLVER_WINNER_EN
  ,
  parameter int IDX_W   = 1
`endif
) (
  input  logic [NUM_DRV-1:0]   en,
  input  logic [NUM_DRV-1:0]   val,
  input  logic [NUM_DRV*3-1:0] s0,
  input  logic [NUM_DRV*3-1:0] s1,
  output logic [2:0]           m0,
  output logic [2:0]           m1
`ifdef STRENGTH_RESOLVER_WINNER_EN
  ,
  output logic [IDX_W-1:0]     idx0,
  output logic [IDX_W-1:0]     idx1
`endif
);

  always_comb begin
    m0 = '0;
    m1 = '0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
    idx0 = '0;
    idx1 = '0;
`endif
    // strict-greater update keeps the lowest index on ties
    for (int d = 0; d < NUM_DRV; d++) begin
      if (en[d]) begin
        if (val[d]) begin
`ifdef STRENGTH_RESOLVER_WINNER_EN
          if (s1[d*3 +: 3] > m1) idx1 = IDX_W'(d);
`endif
          m1 = max_strength(m1, s1[d*3 +: 3]);
        end else begin
`ifdef STRENGTH_RESOLVER_WINNER_EN
          if (s0[d*3 +: 3] > m0) idx0 = IDX_W'(d);
`endif
          m0 = max_strength(m0, s0[d*3 +: 3]);
        end
      end
    end
  end

endmodule

// File: rtl/strength_resolver.sv
// Two-stage pipelined multi-driver net resolver with contention accounting.
// Optional winner-index output is enabled by defining STRENGTH_RESOLVER_WINNER_EN.
module strength_resolver
  import strength_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_DRV = 3,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NUM_DRV-1:0]         drv_en,
  input  logic [NUM_DRV*WIDTH-1:0]   drv_val,
  input  logic [NUM_DRV*3-1:0]       drv_s0,
  input  logic [NUM_DRV*3-1:0]       drv_s1,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_val,
  output logic [WIDTH-1:0]           out_xz,
  output logic [WIDTH*3-1:0]         out_str,
  output logic [CNT_W-1:0]           conflict_cnt,
  output logic                       conflict_sticky
`ifdef STRENGTH_RESOLVER_WINNER_EN
  ,
  output logic [WIDTH*((NUM_DRV > 1) ? $clog2(NUM_DRV) : 1)-1:0] win_idx
`endif
);

`ifdef STRENGTH_RESOLVER_WINNER_EN
  localparam int IDX_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;
  logic [WIDTH*IDX_W-1:0] i0_c, i1_c, s1_i0, s1_i1, win_nxt;
`endif

  logic [WIDTH*3-1:0] m0_c, m1_c, s1_m0, s1_m1;
  logic               s1_valid;
  logic [WIDTH-1:0]   val_nxt, xz_nxt;
  logic [WIDTH*3-1:0] str_nxt;
  logic               any_x;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_DRV-1:0] bv;
    for (genvar d = 0; d < NUM_DRV; d++) begin : g_drv
      assign bv[d] = drv_val[d*WIDTH + b];
    end
    strength_bit_reduce #(
      .NUM_DRV(NUM_DRV)
`ifdef STRENGTH_RESOLVER_WINNER_EN
      ,
      .IDX_W  (IDX_W)
`endif
    ) u_reduce (
      .en  (drv_en),
      .val (bv),
      .s0  (drv_s0),
      .s1  (drv_s1),
      .m0  (m0_c[b*3 +: 3]),
      .m1  (m1_c[b*3 +: 3])
`ifdef STRENGTH_RESOLVER_WINNER_EN
      ,
      .idx0(i0_c[b*IDX_W +: IDX_W]),
      .idx1(i1_c[b*IDX_W +: IDX_W])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_m0    <= '0;
      s1_m1    <= '0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
      s1_i0    <= '0;
      s1_i1    <= '0;
`endif
    end else begin
      s1_valid <= in_valid;
      s1_m0    <= m0_c;
      s1_m1    <= m1_c;
`ifdef STRENGTH_RESOLVER_WINNER_EN
      s1_i0    <= i0_c;
      s1_i1    <= i1_c;
`endif
    end
  end

  always_comb begin
    val_nxt = '0;
    xz_nxt  = '0;
    str_nxt = '0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
    win_nxt = '0;
`endif
    for (int b = 0; b < WIDTH; b++) begin
      if (s1_m0[b*3 +: 3] == 3'd0 && s1_m1[b*3 +: 3] == 3'd0) begin
        {xz_nxt[b], val_nxt[b]} = FS_Z;
      end else if (s1_m1[b*3 +: 3] > s1_m0[b*3 +: 3]) begin
        {xz_nxt[b], val_nxt[b]} = FS_ONE;
        str_nxt[b*3 +: 3]       = s1_m1[b*3 +: 3];
`ifdef STRENGTH_RESOLVER_WINNER_EN
        win_nxt[b*IDX_W +: IDX_W] = s1_i1[b*IDX_W +: IDX_W];
`endif
      end else if (s1_m0[b*3 +: 3] > s1_m1[b*3 +: 3]) begin
        {xz_nxt[b], val_nxt[b]} = FS_ZERO;
        str_nxt[b*3 +: 3]       = s1_m0[b*3 +: 3];
`ifdef STRENGTH_RESOLVER_WINNER_EN
        win_nxt[b*IDX_W +: IDX_W] = s1_i0[b*IDX_W +: IDX_W];
`endif
      end else begin
        {xz_nxt[b], val_nxt[b]} = FS_X;
        str_nxt[b*3 +: 3]       = s1_m0[b*3 +: 3];
      end
    end
    any_x = |(xz_nxt & val_nxt);
  end

  // outputs only load on a valid sample, so they hold between samples
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_xz    <= '1;
      out_str   <= '0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
      win_idx   <= '0;
`endif
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_val <= val_nxt;
        out_xz  <= xz_nxt;
        out_str <= str_nxt;
`ifdef STRENGTH_RESOLVER_WINNER_EN
        win_idx <= win_nxt;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (s1_valid && any_x) begin
      if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
      conflict_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_strength_resolver.sv
// Directed bench for strength_resolver: WIDTH=2, NUM_DRV=3, CNT_W=2.
// Define STRENGTH_RESOLVER_WINNER_EN to also check win_idx.
module tb_strength_resolver;

  localparam int WIDTH   = 2;
  localparam int NUM_DRV = 3;
  localparam int CNT_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [NUM_DRV-1:0]       drv_en;
  logic [NUM_DRV*WIDTH-1:0] drv_val;
  logic [NUM_DRV*3-1:0]     drv_s0, drv_s1;
  logic                     cnt_clr;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_val, out_xz;
  logic [WIDTH*3-1:0]       out_str;
  logic [CNT_W-1:0]         conflict_cnt;
  logic                     conflict_sticky;
`ifdef STRENGTH_RESOLVER_WINNER_EN
  logic [WIDTH*2-1:0]       win_idx;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  strength_resolver #(.WIDTH(WIDTH), .NUM_DRV(NUM_DRV), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .drv_en         (drv_en),
    .drv_val        (drv_val),
    .drv_s0         (drv_s0),
    .drv_s1         (drv_s1),
    .cnt_clr        (cnt_clr),
    .out_valid      (out_valid),
    .out_val        (out_val),
    .out_xz         (out_xz),
    .out_str        (out_str),
    .conflict_cnt   (conflict_cnt),
    .conflict_sticky(conflict_sticky)
`ifdef STRENGTH_RESOLVER_WINNER_EN
    ,
    .win_idx        (win_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] en, input logic [5:0] val,
                       input logic [8:0] s0, input logic [8:0] s1);
    in_valid = v;
    drv_en   = en;
    drv_val  = val;
    drv_s0   = s0;
    drv_s1   = s1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] val,
                           input logic [1:0] xz, input logic [5:0] str,
                           input logic [1:0] cnt, input logic st, input logic [3:0] win);
    chk({tag, ".valid"},  32'(out_valid), 32'(v));
    chk({tag, ".val"},    32'(out_val),   32'(val));
    chk({tag, ".xz"},     32'(out_xz),    32'(xz));
    chk({tag, ".str"},    32'(out_str),   32'(str));
    chk({tag, ".cnt"},    32'(conflict_cnt), 32'(cnt));
    chk({tag, ".sticky"}, 32'(conflict_sticky), 32'(st));
`ifdef STRENGTH_RESOLVER_WINNER_EN
    chk({tag, ".win"},    32'(win_idx),   32'(win));
`else
    if (win != 4'hf) begin end
`endif
  endtask

  // Present one sample, then idle; result is checked two edges later.
  task automatic run1(input string tag, input logic [2:0] en, input logic [5:0] val,
                      input logic [8:0] s0, input logic [8:0] s1,
                      input logic [1:0] e_val, input logic [1:0] e_xz, input logic [5:0] e_str,
                      input logic [1:0] e_cnt, input logic e_st, input logic [3:0] e_win);
    drive(1'b1, en, val, s0, s1);
    tick;
    in_valid = 1'b0;
    tick;
    check_out(tag, 1'b1, e_val, e_xz, e_str, e_cnt, e_st, e_win);
  endtask

  // Reusable vectors: drv_val = {d2,d1,d0} each [bit1,bit0]; strengths {d2,d1,d0}
  localparam logic [5:0] VA_VAL = 6'b10_01_01;
  localparam logic [8:0] VA_S0  = 9'b110_011_011;
  localparam logic [8:0] VA_S1  = 9'b110_111_011;
  localparam logic [5:0] VX_VAL = 6'b00_11_10;
  localparam logic [8:0] VX_S   = 9'b000_110_110;
  localparam logic [8:0] VP_S   = 9'b000_000_101;

  logic [1:0] exp_cnt [5];

  initial begin
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    cnt_clr = 1'b0;
    drive(1'b0, 3'b000, '0, '0, '0);
    tick;
    tick;
    check_out("reset", 1'b0, 2'b00, 2'b11, 6'd0, 2'd0, 1'b0, 4'd0);
    rst = 1'b0;
    tick;

    // bit0: supply1 beats strong0; bit1: strong1 beats weak0
    run1("strongest_wins", 3'b111, VA_VAL, VA_S0, VA_S1,
         2'b11, 2'b00, 6'b110_111, 2'd0, 1'b0, 4'b10_01);
    // bit0 strong0 vs strong1 -> X
    run1("contention", 3'b011, VX_VAL, VX_S, VX_S,
         2'b11, 2'b01, 6'b110_110, 2'd1, 1'b1, 4'd0);
    run1("all_disabled", 3'b000, 6'b111111, 9'h1ff, 9'h1ff,
         2'b00, 2'b11, 6'd0, 2'd1, 1'b1, 4'd0);
    run1("single_pull0", 3'b001, 6'b00_00_00, VP_S, VP_S,
         2'b00, 2'b00, 6'b101_101, 2'd1, 1'b1, 4'd0);
    // d1 enabled with highz strengths must not disturb the pull driver
    run1("highz_no_drive", 3'b011, 6'b00_01_10, VP_S, VP_S,
         2'b10, 2'b00, 6'b101_101, 2'd1, 1'b1, 4'd0);
    tick;
    check_out("hold_idle", 1'b0, 2'b10, 2'b00, 6'b101_101, 2'd1, 1'b1, 4'd0);
    run1("highz_only", 3'b010, 6'b00_11_00, 9'd0, 9'd0,
         2'b00, 2'b11, 6'd0, 2'd1, 1'b1, 4'd0);
    // d0/d2 supply0 vs d1 weak1
    run1("winner_low_idx", 3'b111, 6'b00_11_00, 9'b111_000_111, 9'b000_011_000,
         2'b00, 2'b00, 6'b111_111, 2'd1, 1'b1, 4'd0);

    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    chk("clr.cnt", 32'(conflict_cnt), 32'd0);
    chk("clr.sticky", 32'(conflict_sticky), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run1($sformatf("saturate%0d", i), 3'b011, VX_VAL, VX_S, VX_S,
           2'b11, 2'b01, 6'b110_110, exp_cnt[i], 1'b1, 4'd0);
    end

    // clear lands in the same cycle the sixth contention sample is accounted
    drive(1'b1, 3'b011, VX_VAL, VX_S, VX_S);
    tick;
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick;
    cnt_clr  = 1'b0;
    check_out("clr_priority", 1'b1, 2'b11, 2'b01, 6'b110_110, 2'd0, 1'b0, 4'd0);
    tick;
    chk("clr_after.cnt", 32'(conflict_cnt), 32'd0);

    // back-to-back A, B, C then reset kills C
    drive(1'b1, 3'b111, VA_VAL, VA_S0, VA_S1);
    tick;
    drive(1'b1, 3'b001, 6'b00_00_00, VP_S, VP_S);
    tick;
    check_out("pipe_a", 1'b1, 2'b11, 2'b00, 6'b110_111, 2'd0, 1'b0, 4'b10_01);
    drive(1'b1, 3'b011, VX_VAL, VX_S, VX_S);
    tick;
    check_out("pipe_b", 1'b1, 2'b00, 2'b00, 6'b101_101, 2'd0, 1'b0, 4'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_out("mid_reset", 1'b0, 2'b00, 2'b11, 6'd0, 2'd0, 1'b0, 4'd0);
    tick;
    check_out("no_c_out", 1'b0, 2'b00, 2'b11, 6'd0, 2'd0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
